// File: rtl/tensor_tile_sequencer.sv
// Tile-loop sequencer for a 2x2 int8 systolic feeder: walks output tiles (i,j) over k,
// fetching one A and one B tile word per step; all outputs are registered.
module tensor_tile_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [16:0]       size,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_gnt,
   input  logic              rd_rvalid,
   input  logic [DATA_W-1:0] rd_rdata,
   output logic [DATA_W-1:0] inA,
   output logic [DATA_W-1:0] inB,
   output logic              feed_a,
   output logic              feed_b,
   input  logic              feed_ready,
   output logic              tile_last,
   output logic [15:0]       tile_row,
   output logic [15:0]       tile_col,
   input  logic              drain_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      IDLE, RD_A, WT_A, RD_B, WT_B, FEED_A, FEED_B, DRAIN, DONE
   } state_t;

   state_t            state;
   logic [15:0]       t, i, j, k;
   logic [ADDR_W-1:0] job_base_a, job_base_b;
   logic              size_ok;

   assign size_ok = !size[0] && (size >= 17'd2) && (size <= 17'd131070);

   // Index product kept in 32 bits so T = 65535 cannot overflow before the word shift.
   function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [15:0] row,
                                                   input logic [15:0] col,
                                                   input logic [15:0] dim);
      logic [31:0] idx;
      idx = 32'(row) * 32'(dim) + 32'(col);
      return base + (ADDR_W'(idx) << 2);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         t          <= '0;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         job_base_a <= '0;
         job_base_b <= '0;
         rd_req     <= 1'b0;
         rd_addr    <= '0;
         inA        <= '0;
         inB        <= '0;
         feed_a     <= 1'b0;
         feed_b     <= 1'b0;
         tile_last  <= 1'b0;
         tile_row   <= '0;
         tile_col   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         feed_a <= 1'b0;
         feed_b <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (size_ok) begin
                     t          <= size[16:1];
                     job_base_a <= base_a;
                     job_base_b <= base_b;
                     i          <= '0;
                     j          <= '0;
                     k          <= '0;
                     rd_addr    <= base_a;
                     rd_req     <= 1'b1;
                     busy       <= 1'b1;
                     state      <= RD_A;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RD_A: begin
               if (rd_gnt) begin
                  rd_req <= 1'b0;
                  state  <= WT_A;
               end
            end
            WT_A: begin
               if (rd_rvalid) begin
                  inA     <= rd_rdata;
                  rd_addr <= tile_addr(job_base_b, k, j, t);
                  rd_req  <= 1'b1;
                  state   <= RD_B;
               end
            end
            RD_B: begin
               if (rd_gnt) begin
                  rd_req <= 1'b0;
                  state  <= WT_B;
               end
            end
            WT_B: begin
               if (rd_rvalid) begin
                  inB   <= rd_rdata;
                  state <= FEED_A;
               end
            end
            FEED_A: begin
               if (feed_ready) begin
                  feed_a <= 1'b1;
                  state  <= FEED_B;
               end
            end
            FEED_B: begin
               if (feed_ready) begin
                  feed_b <= 1'b1;
                  if (k != t - 16'd1) begin
                     k       <= k + 16'd1;
                     rd_addr <= tile_addr(job_base_a, i, k + 16'd1, t);
                     rd_req  <= 1'b1;
                     state   <= RD_A;
                  end else begin
                     tile_last <= 1'b1;
                     tile_row  <= i;
                     tile_col  <= j;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_ack) begin
                  tile_last <= 1'b0;
                  k         <= '0;
                  if (j != t - 16'd1) begin
                     j       <= j + 16'd1;
                     rd_addr <= tile_addr(job_base_a, i, '0, t);
                     rd_req  <= 1'b1;
                     state   <= RD_A;
                  end else begin
                     j <= '0;
                     if (i != t - 16'd1) begin
                        i       <= i + 16'd1;
                        rd_addr <= tile_addr(job_base_a, i + 16'd1, '0, t);
                        rd_req  <= 1'b1;
                        state   <= RD_A;
                     end else begin
                        done  <= 1'b1;
                        state <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tensor_tile_sequencer.sv
// Directed bench for tensor_tile_sequencer: table of jobs checked against a loop-order
// model of addresses, tile words and tile coordinates, plus hand sequences for corners.
module tb_tensor_tile_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, feed_ready, drain_ack;
   logic [16:0] size;
   logic [31:0] base_a, base_b, rd_addr, rd_rdata, inA, inB;
   logic        rd_req, rd_gnt, rd_rvalid, feed_a, feed_b, tile_last, busy, done, err;
   logic [15:0] tile_row, tile_col;

   logic        auto_mode;
   logic        a_gnt, a_rvalid, m_gnt, m_rvalid;
   logic [31:0] a_rdata, m_rdata;
   int          lat_max = 0;
   int          drain_delay = 0;

   assign rd_gnt    = auto_mode ? a_gnt    : m_gnt;
   assign rd_rvalid = auto_mode ? a_rvalid : m_rvalid;
   assign rd_rdata  = auto_mode ? a_rdata  : m_rdata;

   tensor_tile_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .size(size),
      .base_a(base_a), .base_b(base_b),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
      .inA(inA), .inB(inB), .feed_a(feed_a), .feed_b(feed_b), .feed_ready(feed_ready),
      .tile_last(tile_last), .tile_row(tile_row), .tile_col(tile_col),
      .drain_ack(drain_ack), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bijective address-to-data map so every tile word is distinguishable.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5C3, a[31:16] ^ a[15:0]};
   endfunction

   // Observation records, each written by one process only.
   logic [31:0] addr_q[$];
   logic [31:0] pa_q[$];
   logic [31:0] pb_q[$];
   logic [31:0] tile_q[$];
   int cyc = 0, done_cnt = 0, err_cnt = 0, drain_viol = 0, tl_cycles = 0;
   int fa_cyc = 0, fb_cyc = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin : mem_resp
      logic [31:0] ad;
      int          w;
      a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
      forever begin
         @(negedge clk);
         a_gnt = 1'b0; a_rvalid = 1'b0;
         if (auto_mode && reset && rd_req) begin
            w = (lat_max > 0) ? int'($urandom_range(lat_max)) : 0;
            for (int n = 0; n < w; n++) begin
               a_rvalid = 1'($urandom_range(1));
               a_rdata  = 32'hDEAD_0000 + 32'(n);
               @(negedge clk);
            end
            ad = rd_addr;
            addr_q.push_back(ad);
            a_gnt    = 1'b1;
            a_rvalid = (lat_max > 0) ? 1'($urandom_range(1)) : 1'b0;
            a_rdata  = 32'hBAD0_0000;
            @(negedge clk);
            a_gnt = 1'b0; a_rvalid = 1'b0;
            w = (lat_max > 0) ? int'($urandom_range(lat_max)) : 0;
            for (int n = 0; n < w; n++) @(negedge clk);
            a_rvalid = 1'b1;
            a_rdata  = mem(ad);
         end
      end
   end

   initial begin : drain_resp
      drain_ack = 1'b0;
      forever begin
         @(negedge clk);
         drain_ack = 1'b0;
         if (tile_last) begin
            for (int n = 0; n < drain_delay; n++) @(negedge clk);
            drain_ack = 1'b1;
         end else if (lat_max > 0) begin
            drain_ack = 1'($urandom_range(1));
         end
      end
   end

   initial begin : monitor
      logic        prev_tl;
      logic [31:0] held;
      prev_tl = 1'b0; held = '0;
      forever begin
         @(negedge clk);
         if (feed_a) begin pa_q.push_back(inA); fa_cyc = cyc; end
         if (feed_b) begin pb_q.push_back(inB); fb_cyc = cyc; end
         if (tile_last) begin
            if (!prev_tl) begin
               held = {tile_row, tile_col};
               tile_q.push_back(held);
            end else if ({tile_row, tile_col} !== held) begin
               drain_viol++;
            end
            if (rd_req) drain_viol++;
            tl_cycles++;
         end
         prev_tl = tile_last;
         if (done) done_cnt++;
         if (err) err_cnt++;
      end
   end

   typedef struct {
      logic [16:0] sz;
      logic [31:0] ba;
      logic [31:0] bb;
      bit          inject;
      int          dly;
      int          lat;
      bit          exp_err;
      int          exp_tiles;
      int          exp_reads;
   } vec_t;

   vec_t vecs[12];

   task automatic pulse_start(input logic [16:0] sz, input logic [31:0] ba, input logic [31:0] bb);
      @(negedge clk);
      start = 1'b1; size = sz; base_a = ba; base_b = bb;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_job(input vec_t v, input int idx);
      int a0, p0, b0, t0, d0, e0, v0, l0, tt, waited;
      logic [31:0] ea[$];
      logic [31:0] eA[$];
      logic [31:0] eB[$];
      logic [31:0] et[$];
      logic [31:0] aa, ab;
      lat_max = v.lat; drain_delay = v.dly;
      a0 = addr_q.size(); p0 = pa_q.size(); b0 = pb_q.size(); t0 = tile_q.size();
      d0 = done_cnt; e0 = err_cnt; v0 = drain_viol; l0 = tl_cycles;
      pulse_start(v.sz, v.ba, v.bb);
      if (v.exp_err) begin
         repeat (3) @(negedge clk);
         check($sformatf("v%0d_err_pulses", idx), 64'(err_cnt - e0), 64'd1);
         check($sformatf("v%0d_err_busy", idx), 64'(busy), 64'd0);
         check($sformatf("v%0d_err_reads", idx), 64'(addr_q.size() - a0), 64'd0);
         return;
      end
      check($sformatf("v%0d_busy_after_start", idx), 64'(busy), 64'd1);
      if (v.inject) begin
         repeat (3) @(negedge clk);
         pulse_start(17'd8, 32'h9000, 32'hA000);
      end
      waited = 0;
      while (done_cnt == d0 && waited < 5000) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("v%0d_done_seen", idx), 64'(waited < 5000), 64'd1);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_done_count", idx), 64'(done_cnt - d0), 64'd1);
      check($sformatf("v%0d_busy_end", idx), 64'(busy), 64'd0);
      check($sformatf("v%0d_no_err", idx), 64'(err_cnt - e0), 64'd0);
      check($sformatf("v%0d_tiles", idx), 64'(tile_q.size() - t0), 64'(v.exp_tiles));
      check($sformatf("v%0d_reads", idx), 64'(addr_q.size() - a0), 64'(v.exp_reads));
      check($sformatf("v%0d_feed_a_cnt", idx), 64'(pa_q.size() - p0), 64'(v.exp_reads / 2));
      check($sformatf("v%0d_feed_b_cnt", idx), 64'(pb_q.size() - b0), 64'(v.exp_reads / 2));
      check($sformatf("v%0d_drain_stable", idx), 64'(drain_viol - v0), 64'd0);
      check($sformatf("v%0d_drain_cycles", idx), 64'(tl_cycles - l0), 64'(v.exp_tiles * (v.dly + 1)));
      tt = int'(v.sz) / 2;
      for (int i = 0; i < tt; i++)
         for (int j = 0; j < tt; j++) begin
            et.push_back({16'(i), 16'(j)});
            for (int k = 0; k < tt; k++) begin
               aa = v.ba + 32'((i * tt + k) * 4);
               ab = v.bb + 32'((k * tt + j) * 4);
               ea.push_back(aa); ea.push_back(ab);
               eA.push_back(mem(aa)); eB.push_back(mem(ab));
            end
         end
      foreach (ea[n])
         if (a0 + n < addr_q.size())
            check($sformatf("v%0d_addr%0d", idx, n), 64'(addr_q[a0 + n]), 64'(ea[n]));
      foreach (eA[n]) begin
         if (p0 + n < pa_q.size())
            check($sformatf("v%0d_wordA%0d", idx, n), 64'(pa_q[p0 + n]), 64'(eA[n]));
         if (b0 + n < pb_q.size())
            check($sformatf("v%0d_wordB%0d", idx, n), 64'(pb_q[b0 + n]), 64'(eB[n]));
      end
      foreach (et[n])
         if (t0 + n < tile_q.size())
            check($sformatf("v%0d_tile%0d", idx, n), 64'(tile_q[t0 + n]), 64'(et[n]));
   endtask

   initial begin : main
      int a0, p0, b0, d0, w;
      reset = 1'b0; start = 1'b0; size = '0; base_a = '0; base_b = '0;
      feed_ready = 1'b1; auto_mode = 1'b1;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

      #12;
      check("rst_ctrl", 64'({rd_req, feed_a, feed_b, tile_last, busy, done, err}), 64'd0);
      check("rst_rd_addr", 64'(rd_addr), 64'd0);
      check("rst_inA", 64'(inA), 64'd0);
      check("rst_inB", 64'(inB), 64'd0);
      check("rst_tile_rc", 64'({tile_row, tile_col}), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      vecs[0]  = '{17'd4,      32'h100,      32'h200,  1'b0, 0,  0, 1'b0, 4, 16};
      vecs[1]  = '{17'd2,      32'h0,        32'h40,   1'b0, 0,  0, 1'b0, 1, 2};
      vecs[2]  = '{17'd6,      32'h1000,     32'h2000, 1'b0, 0,  0, 1'b0, 9, 54};
      vecs[3]  = '{17'd5,      32'h100,      32'h200,  1'b0, 0,  0, 1'b1, 0, 0};
      vecs[4]  = '{17'd0,      32'h100,      32'h200,  1'b0, 0,  0, 1'b1, 0, 0};
      vecs[5]  = '{17'd1,      32'h100,      32'h200,  1'b0, 0,  0, 1'b1, 0, 0};
      vecs[6]  = '{17'd131071, 32'h100,      32'h200,  1'b0, 0,  0, 1'b1, 0, 0};
      vecs[7]  = '{17'd4,      32'hFFFF_FFF8, 32'h80,  1'b0, 0,  0, 1'b0, 4, 16};
      vecs[8]  = '{17'd4,      32'h100,      32'h200,  1'b1, 0,  0, 1'b0, 4, 16};
      vecs[9]  = '{17'd4,      32'h500,      32'h600,  1'b0, 10, 0, 1'b0, 4, 16};
      vecs[10] = '{17'd6,      32'h2000,     32'h3000, 1'b0, 0,  3, 1'b0, 9, 54};
      vecs[11] = '{17'd6,      32'h4000,     32'h5000, 1'b0, 3,  2, 1'b0, 9, 54};
      for (int n = 0; n < 12; n++) run_job(vecs[n], n);

      // Feeder backpressure while a single tile pair waits in FEED_A.
      lat_max = 0; drain_delay = 0; feed_ready = 1'b0;
      a0 = addr_q.size(); p0 = pa_q.size(); b0 = pb_q.size(); d0 = done_cnt;
      pulse_start(17'd2, 32'h300, 32'h400);
      w = 0;
      while (addr_q.size() < a0 + 2 && w < 50) begin @(negedge clk); w++; end
      repeat (3) @(negedge clk);
      repeat (5) @(negedge clk);
      check("bp_hold_feed_a", 64'(pa_q.size() - p0), 64'd0);
      check("bp_hold_feed_b", 64'(pb_q.size() - b0), 64'd0);
      feed_ready = 1'b1;
      w = 0;
      while (pb_q.size() == b0 && w < 20) begin @(negedge clk); w++; end
      check("bp_feed_a_cnt", 64'(pa_q.size() - p0), 64'd1);
      check("bp_feed_b_cnt", 64'(pb_q.size() - b0), 64'd1);
      check("bp_consecutive", 64'(fb_cyc - fa_cyc), 64'd1);
      if (pa_q.size() > p0) check("bp_word_a", 64'(pa_q[p0]), 64'(mem(32'h300)));
      if (pb_q.size() > b0) check("bp_word_b", 64'(pb_q[b0]), 64'(mem(32'h400)));
      w = 0;
      while (done_cnt == d0 && w < 50) begin @(negedge clk); w++; end
      check("bp_done", 64'(done_cnt - d0), 64'd1);

      // Largest T: the k*T step of B must reach 65535 words without overflow.
      a0 = addr_q.size();
      pulse_start(17'd131070, 32'h0, 32'h1000_0000);
      w = 0;
      while (addr_q.size() < a0 + 4 && w < 60) begin @(negedge clk); w++; end
      check("bigT_reads", 64'(addr_q.size() >= a0 + 4), 64'd1);
      if (addr_q.size() >= a0 + 4) begin
         check("bigT_addr0", 64'(addr_q[a0]),     64'h0);
         check("bigT_addr1", 64'(addr_q[a0 + 1]), 64'h1000_0000);
         check("bigT_addr2", 64'(addr_q[a0 + 2]), 64'h4);
         check("bigT_addr3", 64'(addr_q[a0 + 3]), 64'h1003_FFFC);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("bigT_abort_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      repeat (10) @(negedge clk);

      // Reset while waiting for the B word, then a stale rvalid after release.
      auto_mode = 1'b0;
      p0 = pa_q.size(); b0 = pb_q.size();
      pulse_start(17'd4, 32'h100, 32'h200);
      w = 0;
      while (!rd_req && w < 20) begin @(negedge clk); w++; end
      m_gnt = 1'b1;
      @(negedge clk);
      m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
      @(negedge clk);
      m_rvalid = 1'b0;
      check("rm_rd_req_b", 64'(rd_req), 64'd1);
      check("rm_addr_b", 64'(rd_addr), 64'h200);
      check("rm_inA", 64'(inA), 64'h1111_2222);
      m_gnt = 1'b1;
      @(negedge clk);
      m_gnt = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("rm_ctrl_zero", 64'({rd_req, feed_a, feed_b, tile_last, busy, done, err}), 64'd0);
      check("rm_addr_zero", 64'(rd_addr), 64'd0);
      check("rm_inA_zero", 64'(inA), 64'd0);
      check("rm_inB_zero", 64'(inB), 64'd0);
      check("rm_tile_zero", 64'({tile_row, tile_col}), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      m_rvalid = 1'b1; m_rdata = 32'h3333_4444;
      @(negedge clk);
      m_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      check("rm_late_inA", 64'(inA), 64'd0);
      check("rm_late_inB", 64'(inB), 64'd0);
      check("rm_late_busy", 64'(busy), 64'd0);
      check("rm_no_strobes", 64'((pa_q.size() - p0) + (pb_q.size() - b0)), 64'd0);
      auto_mode = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tensor_tile_sequencer.md
TENSOR_TILE_SEQUENCER -- requirements
Module: tensor_tile_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, width of the memory address and base registers.
REQ-002 Parameter DATA_W, default 32, width of one packed 2x2 int8 tile word (byte order 11,21,12,22 from MSB down).
REQ-003 Port clk  input  1  rising-edge clock, the only clock.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 Ports: start  input  1  begin job; size  input  17  matrix dimension N; base_a, base_b  input  ADDR_W  word-tile base addresses.
REQ-006 Ports: rd_req  output  1; rd_addr  output  ADDR_W; rd_gnt  input  1; rd_rvalid  input  1; rd_rdata  input  DATA_W  memory read port.
REQ-007 Ports: inA, inB  output  DATA_W  tile words to the array feeder; feed_a, feed_b  output  1  one-cycle strobes; feed_ready  input  1  feeder can accept.
REQ-008 Ports: tile_last  output  1; tile_row, tile_col  output  16  output-tile coordinates; drain_ack  input  1; busy, done, err  output  1.

Function
REQ-009 The block SHALL compute T = size/2 and tile a C = A x B job into output tiles (i,j), each accumulating over k = 0..T-1, with loop order i outer, j middle, k inner.
REQ-010 A start with size odd, size < 2, or size > 131070 SHALL pulse err for 1 cycle and leave the FSM in IDLE.
REQ-011 start while busy=1 SHALL be ignored; size/base_a/base_b SHALL be sampled only on an accepted start.
REQ-012 States: IDLE, RD_A, WT_A, RD_B, WT_B, FEED_A, FEED_B, DRAIN, DONE.
REQ-013 IDLE -> RD_A on a valid start; i, j, k cleared to 0.
REQ-014 RD_A: rd_req=1, rd_addr = base_a + ((i*T + k) << 2), modulo 2^ADDR_W; RD_A -> WT_A on the cycle rd_gnt=1.
REQ-015 WT_A: rd_req=0; on rd_rvalid=1 the block SHALL capture rd_rdata into inA and go to RD_B.
REQ-016 RD_B/WT_B: same rules with rd_addr = base_b + ((k*T + j) << 2); captured into inB; WT_B -> FEED_A.
REQ-017 At most one read SHALL be outstanding; rd_rvalid outside WT_A/WT_B SHALL be ignored.
REQ-018 FEED_A: feed_a=1 for exactly one cycle when feed_ready=1, then FEED_B; with feed_ready=0 the block SHALL stall with no strobe.
REQ-019 FEED_B: feed_b=1 for one cycle when feed_ready=1; so accepted feed_a and feed_b strobes fall on consecutive cycles, A first.
REQ-020 After FEED_B: if k < T-1, increment k and go to RD_A; else go to DRAIN.
REQ-021 DRAIN: tile_last=1 with tile_row=i, tile_col=j held stable until drain_ack=1.
REQ-022 On drain_ack: k=0. If j < T-1, j++ and go to RD_A. Else j=0; if i < T-1, i++ and go to RD_A. Else go to DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; inA/inB SHALL hold their last captured values between captures.
REQ-025 The i*T products SHALL use 32-bit arithmetic, so T = 65535 produces no overflow before the shift.
REQ-026 drain_ack outside DRAIN SHALL be ignored; rd_gnt and rd_rvalid asserted in the same cycle in RD_x SHALL count as grant only.

Reset
REQ-027 When reset=0 the block SHALL asynchronously enter IDLE with rd_req, feed_a, feed_b, tile_last, busy, done and err all 0; rd_addr, inA, inB, i, j, k, tile_row and tile_col 0.
REQ-028 Reset mid-job SHALL abandon the job with no further strobes; any late rd_rvalid after reset release SHALL be ignored.

Verification
REQ-029 Sequence test: size=4, base_a=0x100, base_b=0x200, zero-latency memory -> rd_addr sequence 0x100, 0x200, 0x104, 0x208 for tile (0,0); 4 tile_last; done once; 16 reads total.
REQ-030 Backpressure test: feed_ready held 0 for 5 cycles at FEED_A -> no strobe during the hold; then feed_a and feed_b on consecutive cycles carrying the captured words.
REQ-031 Error and ignored start: size=5 -> err pulse and busy stays 0; a second start mid-job with size=8 -> job completes with the size=4 tile count.
REQ-032 Drain stall: drain_ack delayed 10 cycles -> tile_last, tile_row and tile_col stable, no rd_req in DRAIN.
REQ-033 Random latency: random rd_gnt/rd_rvalid delays, size=6 -> 27 A/B pairs delivered in order, matching a reference model.
REQ-034 Reset mid-job: reset=0 during WT_B -> all outputs 0 immediately, and a spurious rd_rvalid after reset release causes no capture.
